regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter that merges ALU and memory-load results onto a single register-file write port.
// Memory loads normally win; a starved ALU request is promoted once it has waited STARVE cycles.
module regfile_wb_arbiter #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int STARVE = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          m_valid,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_data,
  output logic          m_ready,
  output logic          rf_write,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_busy1,
  output logic          q_busy2
);

  typedef enum logic {MEM_PRI = 1'b0, ALU_PRI = 1'b1} pri_t;

  localparam logic [2:0] STARVE_CNT = 3'(STARVE);

  pri_t       pri_reg;
  logic [2:0] wait_cnt_reg;
  logic [2:0] wait_cnt_next;
  logic       a_req;
  logic       m_req;
  logic       a_grant;
  logic       m_grant;

  // Writes to register 0 are real handshakes but never compete for the port.
  assign a_req = a_valid && (a_addr != '0);
  assign m_req = m_valid && (m_addr != '0);

  always_comb begin
    a_ready = 1'b0;
    m_ready = 1'b0;
    if (rst_n) begin
      if (pri_reg == MEM_PRI) begin
        m_ready = m_valid;
        a_ready = a_valid && !(a_req && m_req);
      end else begin
        a_ready = a_valid;
        m_ready = m_valid && !(m_req && a_req);
      end
    end
  end

  assign a_grant = a_ready && a_req;
  assign m_grant = m_ready && m_req;

  always_comb begin
    wait_cnt_next = '0;
    if (a_req && !a_grant)
      wait_cnt_next = (wait_cnt_reg == 3'd7) ? 3'd7 : wait_cnt_reg + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_reg      <= MEM_PRI;
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      case (pri_reg)
        MEM_PRI: if (wait_cnt_next == STARVE_CNT) pri_reg <= ALU_PRI;
        ALU_PRI: if (!a_valid || a_ready) pri_reg <= MEM_PRI;
        default: pri_reg <= MEM_PRI;
      endcase
    end
  end

  // Address and data only load on a grant so they hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_write <= a_grant || m_grant;
      if (a_grant) begin
        rf_waddr <= a_addr;
        rf_wdata <= a_data;
      end else if (m_grant) begin
        rf_waddr <= m_addr;
        rf_wdata <= m_data;
      end
    end
  end

  function automatic logic pending(input logic [AW-1:0] q);
    return (q != '0) &&
           ((a_valid && (a_addr == q)) ||
            (m_valid && (m_addr == q)) ||
            (rf_write && (rf_waddr == q)));
  endfunction

  assign q_busy1 = pending(q_addr1);
  assign q_busy2 = pending(q_addr2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: expected writes are queued when granted
// stimulus is driven and compared by a monitor as rf_write appears.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int STARVE = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, m_valid;
  logic [AW-1:0] a_addr, m_addr;
  logic [DW-1:0] a_data, m_data;
  logic          a_ready, m_ready;
  logic          rf_write;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] q_addr1, q_addr2;
  logic          q_busy1, q_busy2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            checks = 0;
  int            fails = 0;

  regfile_wb_arbiter #(.DW(DW), .AW(AW), .STARVE(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    m_valid = 1'b0;
    repeat (n) step();
  endtask

  // Scoreboard monitor: every register-file write must match the oldest queued grant.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rf_write) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
            fails++;
            $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                     rf_waddr, rf_wdata, e.addr, e.data);
          end else
            $display("write addr=%0d data=%h ok", rf_waddr, rf_wdata);
        end
        shadow[rf_waddr] = rf_wdata;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1111_1111;
    m_valid = 1'b1; m_addr = 5'd4; m_data = 32'h2222_2222;
    q_addr1 = '0; q_addr2 = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rf_write !== 1'b0) begin fails++; $display("FAIL reset_rf_write: got %b required 0", rf_write); end
    checks++; if (rf_waddr !== '0) begin fails++; $display("FAIL reset_rf_waddr: got %0d required 0", rf_waddr); end
    checks++; if (rf_wdata !== '0) begin fails++; $display("FAIL reset_rf_wdata: got %h required 0", rf_wdata); end
    checks++; if (a_ready !== 1'b0) begin fails++; $display("FAIL reset_a_ready: got %b required 0", a_ready); end
    checks++; if (m_ready !== 1'b0) begin fails++; $display("FAIL reset_m_ready: got %b required 0", m_ready); end
    rst_n = 1'b1;
    a_valid = 1'b0;
    #1;
    checks++; if (m_ready !== 1'b1) begin fails++; $display("FAIL first_grant_m_ready: got %b required 1", m_ready); end
    push_exp(5'd4, 32'h2222_2222);
    $display("reset released, first load to r4 offered");
    step();
    m_valid = 1'b0;
    step();
  endtask

  task automatic test_single();
    m_valid = 1'b1; m_addr = 5'd5; m_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (m_ready !== 1'b1) begin fails++; $display("FAIL single_m_ready: got %b required 1", m_ready); end
    checks++; if (a_ready !== 1'b0) begin fails++; $display("FAIL single_a_ready: got %b required 0", a_ready); end
    checks++; if (rf_write !== 1'b0) begin fails++; $display("FAIL single_no_early_write: got %b required 0", rf_write); end
    push_exp(5'd5, 32'hDEAD_BEEF);
    step();
    m_valid = 1'b0;
    @(negedge clk);
    checks++; if (rf_write !== 1'b1) begin fails++; $display("FAIL single_write_n1: got %b required 1", rf_write); end
    step();
    @(negedge clk);
    checks++; if (rf_write !== 1'b0) begin fails++; $display("FAIL single_write_n2: got %b required 0", rf_write); end
    checks++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL single_hold: got addr=%0d data=%h required addr=5 data=deadbeef", rf_waddr, rf_wdata);
    end
    $display("single load to r5 done");
    step();
  endtask

  // ALU and MEM both hold requests; expect MEM,MEM,MEM,ALU repeating.
  task automatic run_starve(input int cycles, input logic [AW-1:0] aa, input logic [AW-1:0] ma,
                            input logic [DW-1:0] abase, input logic [DW-1:0] mbase);
    logic          exp_alu;
    logic [DW-1:0] ad, md;
    ad = abase; md = mbase;
    a_valid = 1'b1; a_addr = aa; a_data = ad;
    m_valid = 1'b1; m_addr = ma; m_data = md;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      exp_alu = ((c % 4) == 3);
      checks++; if (a_ready !== exp_alu) begin fails++; $display("FAIL starve_a_ready c=%0d: got %b required %b", c, a_ready, exp_alu); end
      checks++; if (m_ready !== !exp_alu) begin fails++; $display("FAIL starve_m_ready c=%0d: got %b required %b", c, m_ready, !exp_alu); end
      if (exp_alu) push_exp(aa, ad); else push_exp(ma, md);
      $display("starve cycle %0d expect %s grant", c, exp_alu ? "ALU" : "MEM");
      step();
      if (exp_alu) begin ad = ad + 1; a_data = ad; end
      else begin md = md + 1; m_data = md; end
    end
  endtask

  task automatic test_starvation();
    run_starve(12, 5'd3, 5'd4, 32'hA000_0000, 32'hB000_0000);
    idle(2);
  endtask

  task automatic test_null();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h0BAD_0BAD;
    m_valid = 1'b1; m_addr = 5'd7; m_data = 32'h0000_0077;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin fails++; $display("FAIL null_a_ready: got %b required 1", a_ready); end
    checks++; if (m_ready !== 1'b1) begin fails++; $display("FAIL null_m_ready: got %b required 1", m_ready); end
    push_exp(5'd7, 32'h0000_0077);
    step();
    a_valid = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    checks++; if (rf_write !== 1'b1 || rf_waddr !== 5'd7) begin
      fails++; $display("FAIL null_single_write: got write=%b addr=%0d required write=1 addr=7", rf_write, rf_waddr);
    end
    step();
    @(negedge clk);
    checks++; if (rf_write !== 1'b0) begin fails++; $display("FAIL null_no_second_write: got %b required 0", rf_write); end
    $display("null write with load to r7 done");
    step();
  endtask

  task automatic test_busy();
    m_valid = 1'b1; m_addr = 5'd9; m_data = 32'h0000_0909;
    q_addr1 = 5'd9; q_addr2 = 5'd0;
    @(negedge clk);
    checks++; if (q_busy1 !== 1'b1) begin fails++; $display("FAIL busy1_pending: got %b required 1", q_busy1); end
    checks++; if (q_busy2 !== 1'b0) begin fails++; $display("FAIL busy2_zero: got %b required 0", q_busy2); end
    push_exp(5'd9, 32'h0000_0909);
    step();
    m_addr = 5'd0;
    @(negedge clk);
    checks++; if (q_busy1 !== 1'b1) begin fails++; $display("FAIL busy1_write_cycle: got %b required 1", q_busy1); end
    checks++; if (q_busy2 !== 1'b0) begin fails++; $display("FAIL busy2_null_req: got %b required 0", q_busy2); end
    step();
    m_valid = 1'b0;
    @(negedge clk);
    checks++; if (q_busy1 !== 1'b0) begin fails++; $display("FAIL busy1_cleared: got %b required 0", q_busy1); end
    $display("busy tracking for r9 done");
    step();
    q_addr1 = '0;
  endtask

  task automatic test_conflict();
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'd2;
    m_valid = 1'b1; m_addr = 5'd6; m_data = 32'd1;
    q_addr2 = 5'd6;
    @(negedge clk);
    checks++; if (m_ready !== 1'b1 || a_ready !== 1'b0) begin
      fails++; $display("FAIL conflict_first: got m_ready=%b a_ready=%b required 1/0", m_ready, a_ready);
    end
    checks++; if (q_busy2 !== 1'b1) begin fails++; $display("FAIL conflict_busy2: got %b required 1", q_busy2); end
    push_exp(5'd6, 32'd1);
    step();
    m_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin fails++; $display("FAIL conflict_second: got a_ready=%b required 1", a_ready); end
    push_exp(5'd6, 32'd2);
    step();
    a_valid = 1'b0;
    step();
    @(negedge clk);
    checks++; if (shadow[6] !== 32'd2) begin fails++; $display("FAIL conflict_final_r6: got %0d required 2", shadow[6]); end
    $display("same-address conflict on r6 done");
    step();
    q_addr2 = '0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      m_valid = 1'b1; m_addr = 5'(10 + i); m_data = 32'hC000_0000 + 32'(i);
      @(negedge clk);
      checks++; if (m_ready !== 1'b1) begin fails++; $display("FAIL b2b_m_ready i=%0d: got %b required 1", i, m_ready); end
      push_exp(5'(10 + i), 32'hC000_0000 + 32'(i));
      $display("back-to-back load %0d to r%0d", i, 10 + i);
      step();
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hE000_0000;
    m_valid = 1'b1; m_addr = 5'd20; m_data = 32'hF000_0020;
    @(negedge clk);
    checks++; if (m_ready !== 1'b1) begin fails++; $display("FAIL rstmid_m_ready: got %b required 1", m_ready); end
    push_exp(5'd20, 32'hF000_0020);
    step();
    m_addr = 5'd21; m_data = 32'hF000_0021;
    #1;
    checks++; if (rf_write !== 1'b1) begin fails++; $display("FAIL rstmid_pre_write: got %b required 1", rf_write); end
    rst_n = 1'b0;
    #1;
    checks++; if (rf_write !== 1'b0) begin fails++; $display("FAIL rstmid_async_drop: got %b required 0", rf_write); end
    checks++; if (rf_waddr !== '0) begin fails++; $display("FAIL rstmid_waddr: got %0d required 0", rf_waddr); end
    exp_q.delete();
    @(negedge clk);
    checks++; if (a_ready !== 1'b0 || m_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_ready: got a=%b m=%b required 0/0", a_ready, m_ready);
    end
    step();
    rst_n = 1'b1;
    $display("reset pulse done, restarting starvation pattern");
    run_starve(8, 5'd3, 5'd21, 32'hE000_0000, 32'hF000_0021);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_single();
    test_starvation();
    test_null();
    test_busy();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL missing_writes: got %0d outstanding required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
